// File: rtl/gate_round_sequencer.sv
// gate_round_sequencer: round controller for the logic-gate puzzle.
// Picks LFSR targets, judges confirms, runs penalty and game end.
module gate_round_sequencer #(
  parameter logic [7:0]  SEED         = 8'h01,
  parameter logic [31:0] ROUND_CYCLES = 32'd500_000_000,
  parameter logic [31:0] BLANK_CYCLES = 32'd25_000_000,
  parameter logic [3:0]  MAX_MISSES   = 4'd3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       confirm,
  input  logic [7:0] selected_gate,
  output logic [7:0] target_gate,
  output logic [7:0] completed_gate,
  output logic [3:0] score,
  output logic [3:0] misses,
  output logic       timer_en,
  output logic       vga_blankout,
  output logic       round_done,
  output logic       game_over,
  output logic       win
);

  typedef enum logic [2:0] {
    IDLE, ARM, PLAY, PENALTY, DONE
  } state_t;

  state_t      state, state_n;
  logic [7:0]  lfsr, lfsr_n;
  logic [2:0]  idx, idx_n;
  logic        arm_first, arm_first_n;
  logic [31:0] play_cnt, play_cnt_n;
  logic [31:0] pen_cnt, pen_cnt_n;
  logic [7:0]  target_n, completed_n;
  logic [3:0]  score_n, misses_n;
  logic        round_done_n, win_n;
  logic [2:0]  cand;
  logic [3:0]  miss_inc;
  logic [7:0]  hit_mask;
  logic        sel_onehot;
  logic        hit, miss;

  // Next-state and next-output logic for the whole game.
  always_comb begin
    state_n      = state;
    lfsr_n       = lfsr;
    idx_n        = idx;
    arm_first_n  = arm_first;
    play_cnt_n   = play_cnt;
    pen_cnt_n    = pen_cnt;
    target_n     = target_gate;
    completed_n  = completed_gate;
    score_n      = score;
    misses_n     = misses;
    round_done_n = 1'b0;
    win_n        = win;
    hit          = 1'b0;
    miss         = 1'b0;
    cand         = arm_first ? lfsr[2:0] : idx;
    miss_inc     = (misses == 4'd15) ? 4'd15 : misses + 4'd1;
    hit_mask     = completed_gate | target_gate;
    sel_onehot   = (selected_gate != 8'd0) &&
                   ((selected_gate & (selected_gate - 8'd1)) == 8'd0);
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          completed_n = 8'd0;
          score_n     = 4'd0;
          misses_n    = 4'd0;
          win_n       = 1'b0;
          lfsr_n      = SEED;
          arm_first_n = 1'b1;
          state_n     = ARM;
        end
      end
      ARM: begin
        arm_first_n = 1'b0;
        if (arm_first)
          lfsr_n = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        if (!completed_gate[cand]) begin
          target_n   = 8'd1 << cand;
          idx_n      = cand;
          play_cnt_n = 32'd0;
          state_n    = PLAY;
        end else begin
          idx_n = cand + 3'd1;
        end
      end
      PLAY: begin
        if (confirm) begin
          if (sel_onehot && selected_gate == target_gate) hit = 1'b1;
          else miss = 1'b1;
        end else if (play_cnt == ROUND_CYCLES - 32'd1) begin
          miss = 1'b1;
        end else begin
          play_cnt_n = play_cnt + 32'd1;
        end
      end
      PENALTY: begin
        if (pen_cnt == BLANK_CYCLES - 32'd1) begin
          play_cnt_n = 32'd0;
          state_n    = PLAY;
        end else begin
          pen_cnt_n = pen_cnt + 32'd1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (hit) begin
      completed_n  = hit_mask;
      score_n      = score + 4'd1;
      round_done_n = 1'b1;
      target_n     = 8'd0;
      if (hit_mask == 8'hFF) begin
        win_n   = 1'b1;
        state_n = DONE;
      end else begin
        arm_first_n = 1'b1;
        state_n     = ARM;
      end
    end
    if (miss) begin
      misses_n = miss_inc;
      if (miss_inc >= MAX_MISSES) begin
        win_n    = 1'b0;
        target_n = 8'd0;
        state_n  = DONE;
      end else begin
        pen_cnt_n = 32'd0;
        state_n   = PENALTY;
      end
    end
  end

  // State and registered outputs; flags decode from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      lfsr           <= SEED;
      idx            <= 3'd0;
      arm_first      <= 1'b0;
      play_cnt       <= 32'd0;
      pen_cnt        <= 32'd0;
      target_gate    <= 8'd0;
      completed_gate <= 8'd0;
      score          <= 4'd0;
      misses         <= 4'd0;
      timer_en       <= 1'b0;
      vga_blankout   <= 1'b0;
      round_done     <= 1'b0;
      game_over      <= 1'b0;
      win            <= 1'b0;
    end else begin
      state          <= state_n;
      lfsr           <= lfsr_n;
      idx            <= idx_n;
      arm_first      <= arm_first_n;
      play_cnt       <= play_cnt_n;
      pen_cnt        <= pen_cnt_n;
      target_gate    <= target_n;
      completed_gate <= completed_n;
      score          <= score_n;
      misses         <= misses_n;
      timer_en       <= (state_n == ARM) || (state_n == PLAY) ||
                        (state_n == PENALTY);
      vga_blankout   <= (state_n == PENALTY);
      round_done     <= round_done_n;
      game_over      <= (state_n == DONE);
      win            <= win_n;
    end
  end

endmodule

// File: tb/tb_gate_round_sequencer.sv
// tb_gate_round_sequencer: randomized self-checking bench.
// Expected targets come from a game-level model of the puzzle rules.
module tb_gate_round_sequencer;

  localparam logic [7:0] SEED = 8'h01;
  localparam int RC = 12;
  localparam int BC = 4;
  localparam int MM = 3;

  logic       clk = 1'b0;
  logic       reset, start, confirm;
  logic [7:0] selected_gate;
  logic [7:0] target_gate, completed_gate;
  logic [3:0] score, misses;
  logic       timer_en, vga_blankout, round_done, game_over, win;

  int checks = 0;
  int failures = 0;

  logic [7:0] m_lfsr, m_done, m_target;
  int         m_score, m_misses;

  gate_round_sequencer #(
    .SEED(SEED), .ROUND_CYCLES(32'(RC)),
    .BLANK_CYCLES(32'(BC)), .MAX_MISSES(4'(MM))
  ) dut (
    .clk(clk), .reset(reset), .start(start), .confirm(confirm),
    .selected_gate(selected_gate), .target_gate(target_gate),
    .completed_gate(completed_gate), .score(score), .misses(misses),
    .timer_en(timer_en), .vga_blankout(vga_blankout),
    .round_done(round_done), .game_over(game_over), .win(win)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: new game.
  task automatic model_start();
    m_lfsr = SEED; m_done = 8'd0;
    m_score = 0; m_misses = 0;
  endtask

  // Model: pick the next free gate, starting from the LFSR index.
  task automatic model_arm();
    int i;
    i = int'(m_lfsr[2:0]);
    m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    while (m_done[i]) i = (i + 1) % 8;
    m_target = 8'd1 << i;
  endtask

  task automatic expect_next_target(input string nm);
    int n;
    model_arm();
    n = 0;
    while (target_gate == 8'd0 && n < 30) begin tick(); n++; end
    checks++;
    if (target_gate !== m_target) begin
      failures++;
      $display("FAIL %s target got=%h exp=%h", nm, target_gate, m_target);
    end
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
    model_start();
  endtask

  task automatic do_hit(input int d);
    repeat (d) tick();
    selected_gate = m_target; confirm = 1'b1;
    tick();
    confirm = 1'b0;
    m_done |= m_target; m_score++;
    checks++;
    if (round_done !== 1'b1 || score !== 4'(m_score) ||
        completed_gate !== m_done || misses !== 4'(m_misses)) begin
      failures++;
      $display("FAIL hit rd=%b sc=%0d cg=%h mi=%0d exp sc=%0d cg=%h mi=%0d",
               round_done, score, completed_gate, misses,
               m_score, m_done, m_misses);
    end
    tick();
    checks++;
    if (round_done !== 1'b0) begin
      failures++;
      $display("FAIL round_done_pulse got=%b exp=0", round_done);
    end
  endtask

  task automatic penalty_check();
    int n;
    n = 0;
    while (vga_blankout && n < 50) begin
      selected_gate = m_target;
      confirm = 1'($urandom_range(0, 1));
      tick();
      confirm = 1'b0;
      n++;
    end
    checks++;
    if (n != BC || score !== 4'(m_score) || misses !== 4'(m_misses) ||
        target_gate !== m_target || timer_en !== 1'b1) begin
      failures++;
      $display("FAIL penalty len=%0d sc=%0d mi=%0d tg=%h te=%b exp len=%0d sc=%0d mi=%0d tg=%h",
               n, score, misses, target_gate, timer_en,
               BC, m_score, m_misses, m_target);
    end
  endtask

  task automatic do_miss();
    logic [7:0] w;
    case ($urandom_range(0, 2))
      0: w = 8'd0;
      1: w = m_target | {m_target[6:0], m_target[7]};
      default: begin
        w = 8'($urandom);
        while (w == m_target) w = 8'($urandom);
      end
    endcase
    repeat ($urandom_range(0, RC - 3)) tick();
    selected_gate = w; confirm = 1'b1;
    tick();
    confirm = 1'b0;
    m_misses++;
    checks++;
    if (misses !== 4'(m_misses) || vga_blankout !== 1'b1 ||
        score !== 4'(m_score)) begin
      failures++;
      $display("FAIL miss sel=%h mi=%0d vga=%b sc=%0d exp mi=%0d vga=1 sc=%0d",
               w, misses, vga_blankout, score, m_misses, m_score);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; confirm = 1'b0; selected_gate = 8'd0;
    tick(); tick();
    checks++;
    if ({target_gate, completed_gate, score, misses, timer_en,
         vga_blankout, round_done, game_over, win} !== '0) begin
      failures++;
      $display("FAIL reset_outputs tg=%h cg=%h sc=%0d mi=%0d te=%b exp all 0",
               target_gate, completed_gate, score, misses, timer_en);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_first_round();
    do_start();
    checks++;
    if (timer_en !== 1'b1 || target_gate !== 8'd0) begin
      failures++;
      $display("FAIL arm_state te=%b tg=%h exp te=1 tg=00",
               timer_en, target_gate);
    end
    model_arm();
    tick();
    checks++;
    if (target_gate !== 8'h02 || target_gate !== m_target ||
        timer_en !== 1'b1 || vga_blankout !== 1'b0) begin
      failures++;
      $display("FAIL first_target tg=%h te=%b vga=%b exp tg=02 te=1 vga=0",
               target_gate, timer_en, vga_blankout);
    end
  endtask

  task automatic test_hit();
    do_hit($urandom_range(0, RC - 3));
    expect_next_target("after_hit");
    checks++;
    if (target_gate !== 8'h04) begin
      failures++;
      $display("FAIL second_target got=%h exp=04", target_gate);
    end
  endtask

  task automatic test_miss_penalty();
    do_miss();
    penalty_check();
  endtask

  task automatic test_timeout_game_over();
    int n;
    for (int r = 0; r < 2; r++) begin
      n = 0;
      while (!vga_blankout && !game_over && n < 100) begin tick(); n++; end
      m_misses++;
      checks++;
      if (n != RC || misses !== 4'(m_misses)) begin
        failures++;
        $display("FAIL timeout%0d play_len=%0d mi=%0d exp len=%0d mi=%0d",
                 r, n, misses, RC, m_misses);
      end
      if (m_misses < MM) penalty_check();
    end
    checks++;
    if (game_over !== 1'b1 || win !== 1'b0 || target_gate !== 8'd0 ||
        timer_en !== 1'b0 || vga_blankout !== 1'b0 ||
        score !== 4'(m_score) || completed_gate !== m_done) begin
      failures++;
      $display("FAIL lose go=%b win=%b tg=%h te=%b sc=%0d cg=%h exp go=1 win=0 tg=00 te=0 sc=%0d cg=%h",
               game_over, win, target_gate, timer_en, score,
               completed_gate, m_score, m_done);
    end
  endtask

  task automatic test_win();
    do_start();
    for (int k = 0; k < 8; k++) begin
      expect_next_target("win_round");
      if (m_misses < MM - 1 && $urandom_range(0, 3) == 0) begin
        do_miss();
        penalty_check();
      end
      do_hit($urandom_range(0, RC - 3));
    end
    checks++;
    if (game_over !== 1'b1 || win !== 1'b1 || completed_gate !== 8'hFF ||
        score !== 4'd8 || target_gate !== 8'd0 || timer_en !== 1'b0) begin
      failures++;
      $display("FAIL win go=%b win=%b cg=%h sc=%0d tg=%h te=%b exp go=1 win=1 cg=ff sc=8 tg=00 te=0",
               game_over, win, completed_gate, score, target_gate, timer_en);
    end
  endtask

  task automatic test_simultaneous();
    do_start();
    expect_next_target("sim_target");
    repeat (RC - 1) tick();
    checks++;
    if (vga_blankout !== 1'b0 || misses !== 4'd0) begin
      failures++;
      $display("FAIL early_timeout vga=%b mi=%0d exp vga=0 mi=0",
               vga_blankout, misses);
    end
    do_hit(0);
    checks++;
    if (vga_blankout !== 1'b0 || misses !== 4'd0 || score !== 4'd1) begin
      failures++;
      $display("FAIL confirm_on_timeout vga=%b mi=%0d sc=%0d exp vga=0 mi=0 sc=1",
               vga_blankout, misses, score);
    end
  endtask

  task automatic test_reset_in_penalty();
    expect_next_target("pre_reset");
    do_miss();
    repeat ($urandom_range(0, BC - 2)) tick();
    checks++;
    if (vga_blankout !== 1'b1) begin
      failures++;
      $display("FAIL in_penalty vga=%b exp=1", vga_blankout);
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({target_gate, completed_gate, score, misses, timer_en,
         vga_blankout, round_done, game_over, win} !== '0) begin
      failures++;
      $display("FAIL reset_penalty tg=%h cg=%h sc=%0d mi=%0d te=%b vga=%b exp all 0",
               target_gate, completed_gate, score, misses,
               timer_en, vga_blankout);
    end
    reset = 1'b0;
    tick();
    do_start();
    model_arm();
    tick();
    checks++;
    if (target_gate !== m_target || timer_en !== 1'b1) begin
      failures++;
      $display("FAIL restart_after_reset tg=%h te=%b exp tg=%h te=1",
               target_gate, timer_en, m_target);
    end
  endtask

  initial begin
    test_reset();
    test_first_round();
    test_hit();
    test_miss_penalty();
    test_timeout_game_over();
    test_win();
    test_simultaneous();
    test_reset_in_penalty();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
